// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry, register-file FSM states
// and the hard-wired zero register index.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue of a producer marks an entry pending,
// a writeback to that entry clears it. Set beats clear on the same entry.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     set_busy,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  output logic [(1<<ADDR_W)-1:0]   busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] busy_nxt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_busy) set_vec[set_addr] = 1'b1;
    if (we0)      clr_vec[wa0]      = 1'b1;
    if (we1)      clr_vec[wa1]      = 1'b1;
    busy_nxt = set_vec | (busy & ~clr_vec);
    // The zero register always holds a valid value, so it is never pending.
    if (ZERO_REG != 0) busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (en) begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file: NUM_RD combinational reads, two write ports (MEM wins
// on collision), write-to-read bypass, busy scoreboard and a post-reset clear sweep.
module rf_multiport
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       init_done,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd0,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       set_busy,
  input  logic [ADDR_W-1:0]          set_addr,
  output logic [(1<<ADDR_W)-1:0]     busy,
  output rf_state_t                  dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  rf_state_t         state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              run;
  logic              we0_eff, we1_eff;
  logic [DATA_W-1:0] mem [DEPTH];

  assign run       = (state == RF_RUN);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == RF_INIT) begin
      cnt_nxt = cnt + CNT_ONE;
      if (cnt == CNT_LAST) state_nxt = RF_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RF_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_done <= (state_nxt == RF_RUN);
    end
  end

  assign we0_eff = we0 && !((ZERO_REG != 0) && (wa0 == ADDR_W'(REG_ZERO)));
  assign we1_eff = we1 && !((ZERO_REG != 0) && (wa1 == ADDR_W'(REG_ZERO)));

  // No reset on the array: the sweep clears it so it can map onto RAM.
  // Port 1 (MEM) is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt[ADDR_W-1:0]] <= '0;
    end else if (!rst) begin
      if (we0_eff) mem[wa0] <= wd0;
      if (we1_eff) mem[wa1] <= wd1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = mem[a];
      if (!run)                                              d = '0;
      else if ((ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO)))  d = '0;
      else if ((BYPASS != 0) && we1 && (wa1 == a))           d = wd1;
      else if ((BYPASS != 0) && we0 && (wa0 == a))           d = wd0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .we0      (we0),
    .wa0      (wa0),
    .we1      (we1),
    .wa1      (wa1),
    .busy     (busy)
  );

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: a bypassing and a non-bypassing instance driven by the
// same stimulus, checked against a behavioural register-file model.
module tb_rf_multiport;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data, rd_data_nb;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, set_addr = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic        set_busy = 1'b0;
  logic        init_done, init_done_nb;
  logic [31:0] busy, busy_nb;
  rf_state_t   st, st_nb;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  bit          m_run;
  int          m_left;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  rf_multiport #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .rd_addr(rd_addr), .rd_data(rd_data),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .set_busy(set_busy), .set_addr(set_addr), .busy(busy), .dbg_state(st)
  );

  rf_multiport #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .init_done(init_done_nb), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .set_busy(set_busy), .set_addr(set_addr), .busy(busy_nb), .dbg_state(st_nb)
  );

  // Reference: what a reader should see given current inputs and model contents.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (!m_run)                       return 32'h0;
    if (a == 5'd0)                    return 32'h0;
    if (byp && we1 && wa1 == a)       return wd1;
    if (byp && we0 && wa0 == a)       return wd0;
    return m_mem[a];
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    logic [31:0] nb;
    @(posedge clk);
    if (rst) begin
      m_run  = 1'b0;
      m_left = 32;
      m_busy = '0;
    end else if (!m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_run = 1'b1;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      nb = m_busy;
      for (int i = 1; i < 32; i++) begin
        if (set_busy && set_addr == i)                        nb[i] = 1'b1;
        else if ((we0 && wa0 == i) || (we1 && wa1 == i))      nb[i] = 1'b0;
      end
      m_busy = nb;
      if (we0 && wa0 != 0) m_mem[wa0] = wd0;
      if (we1 && wa1 != 0) m_mem[wa1] = wd1;
    end
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; set_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 32'h0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busy=%h init_done=%b required busy=0 init_done=0", busy, init_done);
    end
    for (int i = 0; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEAD;
      we1 = 1'b1; wa1 = 5'((i + 31) % 32); wd1 = 32'hBEEF0000 | i;
      set_busy = 1'b1; set_addr = 5'd3;
      rd_addr = {5'd3, 5'((i + 31) % 32)};
      #1;
      checks++;
      if (init_done !== 1'b0 || rd_data !== 64'h0 || busy !== 32'h0) begin
        failures++;
        $display("FAIL init_sweep cyc=%0d init_done=%b rd=%h busy=%h required 0/0/0", i, init_done, rd_data, busy);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (init_done !== 1'b1 || init_done_nb !== 1'b1) begin
      failures++;
      $display("FAIL init_done_after_32 got=%b/%b required 1", init_done, init_done_nb);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      checks++;
      if (rd_data !== 64'h0 || busy !== 32'h0) begin
        failures++;
        $display("FAIL init_cleared addr=%0d rd=%h busy=%h required 0", a, rd_data, busy);
      end
    end
  endtask

  task automatic test_bypass();
    rd_addr = {5'd5, 5'd5};
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h1234 || rd_data_nb[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h nb=%h required 1234 nb=0", rd_data[31:0], rd_data_nb[31:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[63:32] !== 32'h1234 || rd_data_nb[63:32] !== 32'h1234) begin
      failures++;
      $display("FAIL bypass_next_cycle got=%h nb=%h required 1234", rd_data[63:32], rd_data_nb[63:32]);
    end
  endtask

  task automatic test_dual_write();
    rd_addr = {5'd7, 5'd7};
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5555;
    #1;
    checks++;
    if (rd_data !== {32'h5555, 32'h5555}) begin
      failures++;
      $display("FAIL collision_bypass got=%h required 5555 on both ports", rd_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== {32'h5555, 32'h5555} || rd_data_nb[31:0] !== 32'h5555) begin
      failures++;
      $display("FAIL collision_stored got=%h nb=%h required 5555", rd_data, rd_data_nb[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    rd_addr = {5'd0, 5'd0};
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (rd_data !== 64'h0) begin
      failures++;
      $display("FAIL zero_same_cycle got=%h required 0", rd_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
      failures++;
      $display("FAIL zero_next_cycle got=%h nb=%h required 0", rd_data, rd_data_nb);
    end
    set_busy = 1'b1; set_addr = 5'd0;
    tick();
    idle();
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL zero_never_busy got=%b required 0", busy[0]);
    end
  endtask

  task automatic test_scoreboard();
    set_busy = 1'b1; set_addr = 5'd9;
    tick();
    idle();
    checks++;
    if (busy[9] !== 1'b1) begin
      failures++;
      $display("FAIL busy_set got=%b required 1", busy[9]);
    end
    set_busy = 1'b1; set_addr = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
    tick();
    idle();
    checks++;
    if (busy[9] !== 1'b1) begin
      failures++;
      $display("FAIL busy_set_beats_clear got=%b required 1", busy[9]);
    end
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h999;
    tick();
    idle();
    checks++;
    if (busy !== 32'h0) begin
      failures++;
      $display("FAIL busy_clear got=%h required 0", busy);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 400; n++) begin
      we0      = 1'($urandom_range(0, 1));
      we1      = 1'($urandom_range(0, 1));
      wa0      = 5'($urandom_range(0, 31));
      wa1      = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      wd0      = $urandom;
      wd1      = $urandom;
      set_busy = 1'($urandom_range(0, 1));
      set_addr = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom_range(0, 31));
      rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 31));
      rd_addr[9:5] = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
      exp_q.push_back(exp_read(rd_addr[4:0], 1'b1));
      exp_q.push_back(exp_read(rd_addr[9:5], 1'b1));
      exp_q.push_back(exp_read(rd_addr[4:0], 1'b0));
      exp_q.push_back(exp_read(rd_addr[9:5], 1'b0));
      #1;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[31:0] !== e) begin
        failures++;
        $display("FAIL rand_rd0 n=%0d got=%h required %h", n, rd_data[31:0], e);
      end
      e = exp_q.pop_front();
      checks++;
      if (rd_data[63:32] !== e) begin
        failures++;
        $display("FAIL rand_rd1 n=%0d got=%h required %h", n, rd_data[63:32], e);
      end
      e = exp_q.pop_front();
      checks++;
      if (rd_data_nb[31:0] !== e) begin
        failures++;
        $display("FAIL rand_nb_rd0 n=%0d got=%h required %h", n, rd_data_nb[31:0], e);
      end
      e = exp_q.pop_front();
      checks++;
      if (rd_data_nb[63:32] !== e) begin
        failures++;
        $display("FAIL rand_nb_rd1 n=%0d got=%h required %h", n, rd_data_nb[63:32], e);
      end
      tick();
      checks++;
      if (busy !== m_busy || busy_nb !== m_busy) begin
        failures++;
        $display("FAIL rand_busy n=%0d got=%h nb=%h required %h", n, busy, busy_nb, m_busy);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'(i);
      tick();
    end
    idle();
    set_busy = 1'b1; set_addr = 5'd4;
    tick();
    idle();
    rd_addr = {5'd31, 5'd5};
    #1;
    checks++;
    if (busy[4] !== 1'b1 || rd_data !== {32'd31, 32'd5}) begin
      failures++;
      $display("FAIL fill_before_reset busy4=%b rd=%h required 1 and 0000001f00000005", busy[4], rd_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      #1;
      checks++;
      if (init_done !== 1'b0 || busy !== 32'h0 || rd_data !== 64'h0) begin
        failures++;
        $display("FAIL resweep cyc=%0d init_done=%b busy=%h rd=%h required 0/0/0", i, init_done, busy, rd_data);
      end
      tick();
    end
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL resweep_done got=%b required 1", init_done);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_data_nb !== 64'h0 || busy !== 32'h0) begin
        failures++;
        $display("FAIL resweep_cleared addr=%0d rd=%h nb=%h busy=%h required 0", a, rd_data, rd_data_nb, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_random();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
